// File: rtl/tcm_pkg.sv
// Shared widths, port FSM encoding and the response pipeline stage record
// for the tightly-coupled instruction/data memory.
package tcm_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   typedef struct packed {
      logic              vld;
      logic              err;
      logic [DATA_W-1:0] data;
   } tcm_stage_t;

   function automatic int clog2(input int value);
      int width;
      width = 0;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/tcm_port_ctrl.sv
// One memory port: request handshake, range check and the response pipeline
// that delays READY/ERR/RDATA by LATENCY cycles after accept.
//
//   state   | meaning
//   IDLE    | no request outstanding; VALID is accepted on the next edge
//   BUSY    | request accepted, waiting for its READY pulse
module tcm_port_ctrl
   import tcm_pkg::*;
#(
   parameter int DEPTH_WORDS = 8192,
   parameter int LATENCY     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [29:0]       word_addr,
   input  logic [STRB_W-1:0] wstb,
   input  logic [DATA_W-1:0] mem_word,
   output logic [STRB_W-1:0] wr_lanes,
   output logic              ready,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam int IDX_W = clog2(DEPTH_WORDS);

   logic [0:0] state;
   logic       accept;
   logic       in_range;
   tcm_stage_t stage_q [LATENCY];
   tcm_stage_t stage_in;

   assign in_range = (word_addr >> IDX_W) == 30'd0;
   assign accept   = valid && (state == ST_IDLE) && !rst;
   assign wr_lanes = (accept && in_range) ? wstb : '0;

   always_comb begin
      stage_in      = '0;
      stage_in.vld  = accept;
      stage_in.err  = accept && !in_range;
      // The word is read before the accept-edge write lands, so reads are read-first.
      stage_in.data = (accept && in_range && (wstb == '0)) ? mem_word : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else if (accept) begin
         state <= ST_BUSY;
      end else if (ready) begin
         state <= ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= stage_in;
         for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign ready = stage_q[LATENCY-1].vld;
   assign err   = ready && stage_q[LATENCY-1].err;
   assign rdata = ready ? stage_q[LATENCY-1].data : '0;

endmodule

// File: rtl/tcm_memory.sv
// Tightly-coupled I/D memory: two independent request ports in front of
// either separate I and D arrays or one shared dual-port array.
module tcm_memory
   import tcm_pkg::*;
#(
   parameter int    DEPTH_WORDS = 8192,
   parameter int    LATENCY     = 1,
   parameter bit    UNIFIED     = 1'b0,
   parameter string IMEM_FILE   = "",
   parameter string DMEM_FILE   = ""
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              I_MEM_VALID,
   input  logic [31:0]       I_MEM_ADDR,
   input  logic [STRB_W-1:0] I_MEM_WSTB,
   input  logic [DATA_W-1:0] I_MEM_WDATA,
   output logic              I_MEM_READY,
   output logic [DATA_W-1:0] I_MEM_RDATA,
   output logic              I_MEM_ERR,
   input  logic              D_MEM_VALID,
   input  logic [31:0]       D_MEM_ADDR,
   input  logic [STRB_W-1:0] D_MEM_WSTB,
   input  logic [DATA_W-1:0] D_MEM_WDATA,
   output logic              D_MEM_READY,
   output logic [DATA_W-1:0] D_MEM_RDATA,
   output logic              D_MEM_ERR
);

   localparam int IDX_W = clog2(DEPTH_WORDS);

   logic [IDX_W-1:0]  i_idx;
   logic [IDX_W-1:0]  d_idx;
   logic [DATA_W-1:0] i_word;
   logic [DATA_W-1:0] d_word;
   logic [STRB_W-1:0] i_lanes;
   logic [STRB_W-1:0] d_lanes;
   logic              unused_addr_lsb;

   assign i_idx           = I_MEM_ADDR[IDX_W+1:2];
   assign d_idx           = D_MEM_ADDR[IDX_W+1:2];
   assign unused_addr_lsb = ^{I_MEM_ADDR[1:0], D_MEM_ADDR[1:0]};

   tcm_port_ctrl #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .LATENCY    (LATENCY)
   ) u_i_port (
      .clk      (CLK),
      .rst      (RST),
      .valid    (I_MEM_VALID),
      .word_addr(I_MEM_ADDR[31:2]),
      .wstb     (I_MEM_WSTB),
      .mem_word (i_word),
      .wr_lanes (i_lanes),
      .ready    (I_MEM_READY),
      .rdata    (I_MEM_RDATA),
      .err      (I_MEM_ERR)
   );

   tcm_port_ctrl #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .LATENCY    (LATENCY)
   ) u_d_port (
      .clk      (CLK),
      .rst      (RST),
      .valid    (D_MEM_VALID),
      .word_addr(D_MEM_ADDR[31:2]),
      .wstb     (D_MEM_WSTB),
      .mem_word (d_word),
      .wr_lanes (d_lanes),
      .ready    (D_MEM_READY),
      .rdata    (D_MEM_RDATA),
      .err      (D_MEM_ERR)
   );

   generate
      if (UNIFIED) begin : g_unified
         logic [DATA_W-1:0] mem [DEPTH_WORDS];

         assign i_word = mem[i_idx];
         assign d_word = mem[d_idx];

         // D is written after I in the same block, so D owns lanes both ports strobe.
         always_ff @(posedge CLK) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (i_lanes[b]) mem[i_idx][8*b +: 8] <= I_MEM_WDATA[8*b +: 8];
               if (d_lanes[b]) mem[d_idx][8*b +: 8] <= D_MEM_WDATA[8*b +: 8];
            end
         end
      end else begin : g_split
         logic [DATA_W-1:0] imem [DEPTH_WORDS];
         logic [DATA_W-1:0] dmem [DEPTH_WORDS];

         assign i_word = imem[i_idx];
         assign d_word = dmem[d_idx];

         always_ff @(posedge CLK) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (i_lanes[b]) imem[i_idx][8*b +: 8] <= I_MEM_WDATA[8*b +: 8];
            end
         end

         always_ff @(posedge CLK) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (d_lanes[b]) dmem[d_idx][8*b +: 8] <= D_MEM_WDATA[8*b +: 8];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_tcm_memory.sv
// Bench for tcm_memory: three configurations (split/LAT1, unified/LAT3,
// split/LAT4) driven by directed and random requests against a word-array model.
module tb_tcm_memory;

   localparam int NDUT  = 3;
   localparam int DEPTH = 256;

   int lat_of [NDUT] = '{1, 3, 4};
   bit uni_of [NDUT] = '{1'b0, 1'b1, 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NDUT-1:0]       rst, i_valid, d_valid, i_ready, d_ready, i_err, d_err;
   logic [NDUT-1:0][31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
   logic [NDUT-1:0][3:0]  i_wstb, d_wstb;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      tcm_memory #(
         .DEPTH_WORDS(DEPTH),
         .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
         .UNIFIED    (g == 1),
         .IMEM_FILE  (""),
         .DMEM_FILE  ("")
      ) dut (
         .CLK        (clk),
         .RST        (rst[g]),
         .I_MEM_VALID(i_valid[g]),
         .I_MEM_ADDR (i_addr[g]),
         .I_MEM_WSTB (i_wstb[g]),
         .I_MEM_WDATA(i_wdata[g]),
         .I_MEM_READY(i_ready[g]),
         .I_MEM_RDATA(i_rdata[g]),
         .I_MEM_ERR  (i_err[g]),
         .D_MEM_VALID(d_valid[g]),
         .D_MEM_ADDR (d_addr[g]),
         .D_MEM_WSTB (d_wstb[g]),
         .D_MEM_WDATA(d_wdata[g]),
         .D_MEM_READY(d_ready[g]),
         .D_MEM_RDATA(d_rdata[g]),
         .D_MEM_ERR  (d_err[g])
      );
   end

   // Reference contents; a unified configuration uses ref_i for both ports.
   logic [31:0] ref_i [NDUT][DEPTH];
   logic [31:0] ref_d [NDUT][DEPTH];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      check(tag, {31'b0, obs}, {31'b0, exp});
   endtask

   function automatic bit out_of_range(input logic [31:0] a);
      return (a >> 2) >= DEPTH;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] wstb);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (wstb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [31:0] model_rd(input int n, input bit dport, input int idx);
      if (uni_of[n] || !dport) return ref_i[n][idx];
      return ref_d[n][idx];
   endfunction

   task automatic model_wr(input int n, input bit dport, input int idx,
                           input logic [31:0] data, input logic [3:0] wstb);
      if (uni_of[n] || !dport) ref_i[n][idx] = merge(ref_i[n][idx], data, wstb);
      else                     ref_d[n][idx] = merge(ref_d[n][idx], data, wstb);
   endtask

   // Issue one request on either or both ports of DUT n at the current negedge
   // and follow it to its READY pulse; returns the observed read data.
   task automatic do_pair(input int n,
                          input bit ie, input logic [31:0] ia, input logic [3:0] iw, input logic [31:0] id,
                          input bit de, input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd,
                          output logic [31:0] i_obs, output logic [31:0] d_obs);
      logic [31:0] exp_ir, exp_dr;
      bit          exp_ie, exp_de;
      int          ii, di;
      ii     = int'(ia[9:2]);
      di     = int'(da[9:2]);
      exp_ie = ie && out_of_range(ia);
      exp_de = de && out_of_range(da);
      exp_ir = (ie && !out_of_range(ia) && iw == 4'h0) ? model_rd(n, 1'b0, ii) : 32'h0;
      exp_dr = (de && !out_of_range(da) && dw == 4'h0) ? model_rd(n, 1'b1, di) : 32'h0;
      if (ie && !out_of_range(ia)) model_wr(n, 1'b0, ii, id, iw);
      if (de && !out_of_range(da)) model_wr(n, 1'b1, di, dd, dw);

      i_valid[n] = ie; i_addr[n] = ia; i_wstb[n] = iw; i_wdata[n] = id;
      d_valid[n] = de; d_addr[n] = da; d_wstb[n] = dw; d_wdata[n] = dd;
      i_obs = 32'h0;
      d_obs = 32'h0;
      for (int k = 1; k <= lat_of[n]; k++) begin
         @(negedge clk);
         if (k < lat_of[n]) begin
            check_bit("i_ready_early", i_ready[n], 1'b0);
            check_bit("d_ready_early", d_ready[n], 1'b0);
            check("i_rdata_not_ready", i_rdata[n], 32'h0);
            check("d_rdata_not_ready", d_rdata[n], 32'h0);
         end else begin
            check_bit("i_ready", i_ready[n], ie);
            check_bit("d_ready", d_ready[n], de);
            check("i_rdata", i_rdata[n], exp_ir);
            check("d_rdata", d_rdata[n], exp_dr);
            check_bit("i_err", i_err[n], exp_ie);
            check_bit("d_err", d_err[n], exp_de);
            i_obs = i_rdata[n];
            d_obs = d_rdata[n];
         end
      end
      i_valid[n] = 1'b0;
      d_valid[n] = 1'b0;
      @(negedge clk);
      check_bit("i_ready_pulse", i_ready[n], 1'b0);
      check_bit("d_ready_pulse", d_ready[n], 1'b0);
      check("i_rdata_after", i_rdata[n], 32'h0);
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7)       return 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
      else if (r == 7) return 32'h3FC;
      else if (r == 8) return 32'($urandom_range(256, 4000) << 2);
      return $urandom() | 32'h8000_0000;
   endfunction

   initial begin
      logic [31:0] io, dob;
      logic        seen;
      logic [3:0]  iw, dw;
      int          mode;

      rst     = '1;
      i_valid = '0; d_valid = '0;
      i_addr  = '0; d_addr  = '0;
      i_wstb  = '0; d_wstb  = '0;
      i_wdata = '0; d_wdata = '0;

      // Request held through reset must not be served until reset drops.
      i_valid[0] = 1'b1; i_addr[0] = 32'h0; i_wstb[0] = 4'hF; i_wdata[0] = 32'hCAFE0001;
      repeat (2) begin
         @(negedge clk);
         check_bit("rst_i_ready", i_ready[0], 1'b0);
         check_bit("rst_i_err", i_err[0], 1'b0);
         check("rst_i_rdata", i_rdata[0], 32'h0);
         check_bit("rst_d_ready", d_ready[0], 1'b0);
      end
      rst = '0;
      do_pair(0, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);

      // Preload words 0..31 and 255 on every port.
      for (int n = 0; n < NDUT; n++) begin
         for (int w = 0; w < 33; w++) begin
            int idx;
            idx = (w == 32) ? 255 : w;
            do_pair(n, 1'b1, 32'(idx << 2), 4'hF, $urandom(),
                       1'b1, 32'(idx << 2), 4'hF, $urandom(), io, dob);
         end
      end

      // Latency 3 write then read.
      do_pair(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, io, dob);
      do_pair(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h100, 4'h0, 32'h0, io, dob);
      check("lat3_readback", dob, 32'hDEADBEEF);

      // Byte strobes.
      do_pair(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h40, 4'hF, 32'h11223344, io, dob);
      do_pair(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h40, 4'h5, 32'hAABBCCDD, io, dob);
      do_pair(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h40, 4'h0, 32'h0, io, dob);
      check("strobe_readback", dob, 32'h11BB33DD);

      // Out of range and the last in-range word.
      do_pair(0, 1'b1, 32'h400, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);
      do_pair(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h400, 4'hF, 32'h0BADF00D, io, dob);
      do_pair(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, io, dob);
      do_pair(0, 1'b1, 32'h3FC, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);

      // Unified collision: lane 0 from I, lanes 1-2 from D, lane 3 untouched.
      do_pair(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h20, 4'hF, 32'h12345678, io, dob);
      do_pair(1, 1'b1, 32'h20, 4'h3, 32'hFFFFFFFF, 1'b1, 32'h20, 4'h6, 32'h00000000, io, dob);
      do_pair(1, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);
      check("collision_readback", io, 32'h120000FF);
      do_pair(1, 1'b1, 32'h20, 4'h0, 32'h0, 1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, io, dob);
      check("collision_read_old", io, 32'h120000FF);
      do_pair(1, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);

      // Reset two cycles after accept discards the in-flight read.
      i_valid[2] = 1'b1; i_addr[2] = 32'h8; i_wstb[2] = 4'h0; i_wdata[2] = 32'h0;
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen |= i_ready[2];
      end
      rst[2] = 1'b1;
      i_valid[2] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) rst[2] = 1'b0;
         seen |= i_ready[2];
      end
      check_bit("midrst_no_ready", seen, 1'b0);
      do_pair(2, 1'b1, 32'h8, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, io, dob);

      // Random traffic on all configurations.
      for (int n = 0; n < NDUT; n++) begin
         for (int t = 0; t < 80; t++) begin
            mode = int'($urandom_range(0, 2));
            iw   = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            dw   = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_pair(n, mode != 1, rand_addr(), iw, $urandom(),
                       mode != 0, rand_addr(), dw, $urandom(), io, dob);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
